ram_port_arbiter: RTL and testbench

- Arbitrates the single-port effect RAM among NUM_REQ requesters: the config loader, the delay tap reader, and the output sample writer.
- Owns the loc_ram* strobes and runs the two-phase access: RAM clock high with address/command, then RAM clock low with data capture.
- Round-robin grant, one access in flight, registered acknowledge with returned read data.
- Blocks writes into the protected config region below PROT_TOP.

---
 rtl/ram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares the single-port effect RAM between NUM_REQ requesters: the config loader,
// the delay tap reader and the output sample writer. Each access takes two cycles.
// In the first cycle loc_ramclk is high and the address and command are presented.
// In the second cycle loc_ramclk is low, read data is captured and the requester
// sees a one-cycle ack. A round-robin pointer decides which pending request is
// granted. Writes below PROT_TOP, where the config and parameter words live, are
// dropped; they still complete and are flagged on wr_blocked.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   req            per-requester request, held until its ack
//   req_we         per-requester write flag (1 = write)
//   req_addr       packed addresses, requester i at [i*AW +: AW]
//   req_wdata      packed write data, requester i at [i*DW +: DW]
//   ack            one-hot completion pulse
//   rdata          read data, valid in the ack cycle of a read
//   wr_blocked     pulses with ack when a protected write was dropped
//   busy           high while an access is in flight
//   grant_id       index of the current or last granted requester
//   loc_readdata   RAM read data
//   loc_writedata  RAM write data
//   loc_ramaddress RAM address
//   loc_ramclk     RAM clock, generated here
//   loc_ramread    RAM read enable
//   loc_ramwrite   RAM write enable

module ram_port_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned AW       = 15,
    parameter int unsigned DW       = 32,
    parameter int unsigned PROT_TOP = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  wr_blocked,
    output logic                  busy,
    output logic [1:0]            grant_id,
    input  logic [DW-1:0]         loc_readdata,
    output logic [DW-1:0]         loc_writedata,
    output logic [AW-1:0]         loc_ramaddress,
    output logic                  loc_ramclk,
    output logic                  loc_ramread,
    output logic                  loc_ramwrite
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    // Command kind of the access in flight, captured at grant.
    logic       cur_we_q;
    logic       cur_prot_q;

    logic [NUM_REQ-1:0] last_mask;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [1:0]         gnt;
    logic [1:0]         next_ptr;
    logic [AW-1:0]      gnt_addr;
    logic [DW-1:0]      gnt_wdata;
    logic               gnt_we;
    logic               gnt_prot;

    // Requester picking, done combinationally from the registered pointer.
    always_comb begin
        int idx;
        idx       = 0;
        last_mask = NUM_REQ'(1) << grant_id;

        // The requester acked in DONE sits out one arbitration round.
        unique case (state_q)
            StIdle:  eligible = req;
            StDone:  eligible = req & ~last_mask;
            default: eligible = '0;
        endcase

        // Walk from the farthest offset back to the pointer so the closest
        // eligible requester is the last one written and therefore wins.
        found = 1'b0;
        gnt   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (eligible[idx]) begin
                found = 1'b1;
                gnt   = 2'(idx);
            end
        end

        next_ptr = (int'(gnt) == int'(NUM_REQ) - 1) ? 2'd0 : gnt + 2'd1;
    end

    always_comb begin
        gnt_addr  = req_addr[int'(gnt)*AW +: AW];
        gnt_wdata = req_wdata[int'(gnt)*DW +: DW];
        gnt_we    = req_we[gnt];
        gnt_prot  = gnt_addr < AW'(PROT_TOP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            cur_we_q       <= 1'b0;
            cur_prot_q     <= 1'b0;
            ack            <= '0;
            rdata          <= '0;
            wr_blocked     <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= '0;
            loc_writedata  <= '0;
            loc_ramaddress <= '0;
            loc_ramclk     <= 1'b0;
            loc_ramread    <= 1'b0;
            loc_ramwrite   <= 1'b0;
        end else begin
            unique case (state_q)
                // IDLE and DONE share the grant path so back-to-back accesses
                // keep loc_ramclk toggling every cycle.
                StIdle, StDone: begin
                    ack        <= '0;
                    wr_blocked <= 1'b0;
                    if (found) begin
                        loc_ramaddress <= gnt_addr;
                        if (gnt_we) begin
                            loc_writedata <= gnt_wdata;
                        end
                        loc_ramclk   <= 1'b1;
                        loc_ramread  <= !gnt_we;
                        loc_ramwrite <= gnt_we && !gnt_prot;
                        busy         <= 1'b1;
                        grant_id     <= gnt;
                        cur_we_q     <= gnt_we;
                        cur_prot_q   <= gnt_prot;
                        ptr_q        <= next_ptr;
                        state_q      <= StAccess;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StAccess: begin
                    loc_ramclk   <= 1'b0;
                    loc_ramread  <= 1'b0;
                    loc_ramwrite <= 1'b0;
                    ack          <= last_mask;
                    if (!cur_we_q) begin
                        rdata <= loc_readdata;
                    end
                    wr_blocked <= cur_we_q && cur_prot_q;
                    state_q    <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reset values, single read, round-robin
// under full load, plain and protected writes, regrant rules and reset during
// an access.

module tb_ram_port_arbiter;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned AW       = 15;
    localparam int unsigned DW       = 32;
    localparam int unsigned PROT_TOP = 7;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [DW-1:0]         rdata;
    logic                  wr_blocked;
    logic                  busy;
    logic [1:0]            grant_id;
    logic [DW-1:0]         loc_readdata;
    logic [DW-1:0]         loc_writedata;
    logic [AW-1:0]         loc_ramaddress;
    logic                  loc_ramclk;
    logic                  loc_ramread;
    logic                  loc_ramwrite;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .AW      (AW),
        .DW      (DW),
        .PROT_TOP(PROT_TOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .ack           (ack),
        .rdata         (rdata),
        .wr_blocked    (wr_blocked),
        .busy          (busy),
        .grant_id      (grant_id),
        .loc_readdata  (loc_readdata),
        .loc_writedata (loc_writedata),
        .loc_ramaddress(loc_ramaddress),
        .loc_ramclk    (loc_ramclk),
        .loc_ramread   (loc_ramread),
        .loc_ramwrite  (loc_ramwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_ramclk"}, 64'(loc_ramclk), 64'h0);
        chk({tag, "_ramread"}, 64'(loc_ramread), 64'h0);
        chk({tag, "_ramwrite"}, 64'(loc_ramwrite), 64'h0);
        chk({tag, "_wrblk"}, 64'(wr_blocked), 64'h0);
    endtask

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 2, 0};

        reset        = 1'b0;
        req          = '0;
        req_we       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        loc_readdata = '0;

        // Reset values; requesters already waiting for the round-robin test.
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, AW'(32'h100 + i), '0);
        req = 3'b111;
        step();
        step();
        chk_idle_outputs("rst");
        chk("rst_gid", 64'(grant_id), 64'h0);
        chk("rst_addr", 64'(loc_ramaddress), 64'h0);
        chk("rst_wdata", 64'(loc_writedata), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        reset = 1'b1;

        // Round-robin with all three reading: 0,1,2,0 one access per 2 cycles.
        for (int n = 0; n < 4; n++) begin
            step();
            chk($sformatf("rr%0d_ramclk_hi", n), 64'(loc_ramclk), 64'h1);
            chk($sformatf("rr%0d_gid", n), 64'(grant_id), 64'(exp_g[n]));
            chk($sformatf("rr%0d_addr", n), 64'(loc_ramaddress), 64'h100 + 64'(exp_g[n]));
            chk($sformatf("rr%0d_ack_lo", n), 64'(ack), 64'h0);
            loc_readdata = 32'hF000 + 32'(exp_g[n]);
            step();
            chk($sformatf("rr%0d_ramclk_lo", n), 64'(loc_ramclk), 64'h0);
            chk($sformatf("rr%0d_ack", n), 64'(ack), 64'(1 << exp_g[n]));
            chk($sformatf("rr%0d_rdata", n), 64'(rdata), 64'hF000 + 64'(exp_g[n]));
        end
        req = '0;
        step();
        chk_idle_outputs("rr_end");

        // Single read by requester 1 at address 7.
        set_req(1, 1'b0, 15'h0007, '0);
        loc_readdata = 32'h0000_1234;
        req          = 3'b010;
        step();
        chk("rd_ramclk", 64'(loc_ramclk), 64'h1);
        chk("rd_ramread", 64'(loc_ramread), 64'h1);
        chk("rd_ramwrite", 64'(loc_ramwrite), 64'h0);
        chk("rd_addr", 64'(loc_ramaddress), 64'h7);
        chk("rd_busy", 64'(busy), 64'h1);
        chk("rd_gid", 64'(grant_id), 64'h1);
        loc_readdata = 32'h0000_1234;
        step();
        chk("rd_ack", 64'(ack), 64'h2);
        chk("rd_rdata", 64'(rdata), 64'h1234);
        chk("rd_ramclk_lo", 64'(loc_ramclk), 64'h0);
        chk("rd_ramread_lo", 64'(loc_ramread), 64'h0);
        chk("rd_busy_ack", 64'(busy), 64'h1);
        req          = '0;
        loc_readdata = 32'hBAD0_BAD0;
        step();
        chk_idle_outputs("rd_end");

        // Unprotected write by requester 2 at the top address.
        set_req(2, 1'b1, 15'h7FFF, 32'hDEAD_BEEF);
        req = 3'b100;
        step();
        chk("wr_ramwrite", 64'(loc_ramwrite), 64'h1);
        chk("wr_ramread", 64'(loc_ramread), 64'h0);
        chk("wr_wdata", 64'(loc_writedata), 64'hDEAD_BEEF);
        chk("wr_addr", 64'(loc_ramaddress), 64'h7FFF);
        chk("wr_gid", 64'(grant_id), 64'h2);
        step();
        chk("wr_ack", 64'(ack), 64'h4);
        chk("wr_blk", 64'(wr_blocked), 64'h0);
        chk("wr_rdata_hold", 64'(rdata), 64'h1234);
        chk("wr_ramwrite_lo", 64'(loc_ramwrite), 64'h0);
        req = '0;
        step();
        chk_idle_outputs("wr_end");

        // Protected write by requester 0 at address 3: RAM never sees it.
        set_req(0, 1'b1, 15'h0003, 32'h5555_AAAA);
        req = 3'b001;
        step();
        chk("pw_ramwrite", 64'(loc_ramwrite), 64'h0);
        chk("pw_ramread", 64'(loc_ramread), 64'h0);
        chk("pw_ramclk", 64'(loc_ramclk), 64'h1);
        chk("pw_addr", 64'(loc_ramaddress), 64'h3);
        step();
        chk("pw_ack", 64'(ack), 64'h1);
        chk("pw_blk", 64'(wr_blocked), 64'h1);
        req = '0;
        step();
        chk_idle_outputs("pw_end");

        // Boundary: address 7 is the first writable word.
        set_req(0, 1'b1, 15'h0007, 32'h0000_0077);
        req = 3'b001;
        step();
        chk("bw_ramwrite", 64'(loc_ramwrite), 64'h1);
        step();
        chk("bw_blk", 64'(wr_blocked), 64'h0);
        req = '0;
        step();

        // Requester 0 holds req through its ack: not regranted from DONE.
        set_req(0, 1'b0, 15'h0010, '0);
        set_req(1, 1'b0, 15'h0011, '0);
        req = 3'b001;
        step();
        chk("hold_gid0", 64'(grant_id), 64'h0);
        step();
        chk("hold_ack0", 64'(ack), 64'h1);
        step();
        chk("hold_done_busy", 64'(busy), 64'h0);
        chk("hold_done_ramclk", 64'(loc_ramclk), 64'h0);
        chk("hold_done_ack", 64'(ack), 64'h0);
        step();
        chk("hold_regrant_clk", 64'(loc_ramclk), 64'h1);
        chk("hold_regrant_gid", 64'(grant_id), 64'h0);
        step();
        chk("hold_ack0b", 64'(ack), 64'h1);
        req = 3'b011;
        step();
        chk("b2b_ramclk", 64'(loc_ramclk), 64'h1);
        chk("b2b_gid", 64'(grant_id), 64'h1);
        chk("b2b_busy", 64'(busy), 64'h1);
        chk("b2b_addr", 64'(loc_ramaddress), 64'h11);
        req = 3'b010;
        step();
        chk("b2b_ack", 64'(ack), 64'h2);
        req = '0;
        step();
        chk_idle_outputs("b2b_end");

        // Reset while an access is in ACCESS with loc_ramclk high.
        set_req(1, 1'b0, 15'h0020, '0);
        set_req(0, 1'b0, 15'h0021, '0);
        req = 3'b010;
        step();
        chk("ra_ramclk", 64'(loc_ramclk), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle_outputs("ra_rst");
        chk("ra_rst_gid", 64'(grant_id), 64'h0);
        req = 3'b011;
        step();
        chk("ra_held_ack", 64'(ack), 64'h0);
        reset = 1'b1;
        step();
        chk("ra_first_ack", 64'(ack), 64'h0);
        chk("ra_first_gid", 64'(grant_id), 64'h0);
        chk("ra_first_addr", 64'(loc_ramaddress), 64'h21);
        step();
        chk("ra_first_ackd", 64'(ack), 64'h1);
        req = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
